// File: rtl/pe_array_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pe_array_pkg: shared state encoding, default widths, lane narrowing fn.  |
// | Rev 1.0 -- PEARRAY_DRAIN_SAT_EN selects saturation instead of truncation |
// +--------------------------------------------------------------------------+
package pe_array_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int OUTPUT_WIDTH_DEF = 24;
  localparam int OBF_WIDTH_DEF    = 16;
  localparam int CALC_W           = 64;

  // Returns v narrowed to a signed w-bit range, sign-extended back to CALC_W.
  function automatic logic signed [CALC_W-1:0] sat_or_trunc(
    input logic signed [CALC_W-1:0] v,
    input int                       w
  );
`ifdef PEARRAY_DRAIN_SAT_EN
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
`else
    return (v <<< (CALC_W - w)) >>> (CALC_W - w);
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_drain_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pe_drain_lane: per-row arithmetic shift, narrow to OBF width and mask.   |
// | Rev 1.0 -- narrowing mode follows PEARRAY_DRAIN_SAT_EN                   |
// +--------------------------------------------------------------------------+
module pe_drain_lane
  import pe_array_pkg::*;
#(
  parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
  parameter int OBF_WIDTH    = OBF_WIDTH_DEF
) (
  input  logic [OUTPUT_WIDTH-1:0] pe_val_i,
  input  logic [4:0]              shift_i,
  input  logic                    en_i,
  output logic [OBF_WIDTH-1:0]    lane_o
);

  logic signed [CALC_W-1:0] w_ext;
  logic signed [CALC_W-1:0] w_shifted;
  logic signed [CALC_W-1:0] w_narrow;
  logic                     w_unused_hi;

  assign w_ext       = {{(CALC_W-OUTPUT_WIDTH){pe_val_i[OUTPUT_WIDTH-1]}}, pe_val_i};
  assign w_shifted   = w_ext >>> shift_i;
  assign w_narrow    = sat_or_trunc(w_shifted, OBF_WIDTH);
  assign lane_o      = en_i ? w_narrow[OBF_WIDTH-1:0] : '0;
  // Upper bits are just the sign extension of the narrowed value.
  assign w_unused_hi = ^w_narrow[CALC_W-1:OBF_WIDTH];

endmodule
`default_nettype wire

// File: rtl/pe_array_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pe_array_drain: snapshots all PE outputs, drains one column per beat.    |
// | Rev 1.0 -- PEARRAY_DRAIN_SAT_EN enables lane saturation                  |
// +--------------------------------------------------------------------------+
module pe_array_drain
  import pe_array_pkg::*;
#(
  parameter int NB_PE_ROW     = 8,
  parameter int NB_PE_COL     = 32,
  parameter int OUTPUT_WIDTH  = OUTPUT_WIDTH_DEF,
  parameter int OBF_WIDTH     = OBF_WIDTH_DEF,
  parameter int COL_IDX_WIDTH = (NB_PE_COL > 1) ? $clog2(NB_PE_COL) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NB_PE_ROW*NB_PE_COL*OUTPUT_WIDTH-1:0] pe_out_all,
  input  logic                                      load_req,
  output logic                                      load_ack,
  input  logic [NB_PE_ROW-1:0]                      row_en,
  input  logic                                      drain_dir,
  input  logic [4:0]                                out_shift,
  output logic                                      drain_valid,
  input  logic                                      drain_ready,
  output logic [NB_PE_ROW*OBF_WIDTH-1:0]            drain_data,
  output logic [COL_IDX_WIDTH-1:0]                  drain_col,
  output logic                                      drain_last,
  output logic                                      busy
);

  localparam logic [COL_IDX_WIDTH-1:0] c_last_k = COL_IDX_WIDTH'(NB_PE_COL - 1);

  state_e                   state_q;
  logic [COL_IDX_WIDTH-1:0] k_q;
  logic [COL_IDX_WIDTH-1:0] k_d;
  logic [OUTPUT_WIDTH-1:0]  snap_q [NB_PE_ROW][NB_PE_COL];
  logic [NB_PE_ROW-1:0]     row_en_q;
  logic                     dir_q;
  logic [4:0]               shift_q;

  logic                     w_load;
  logic                     w_last;

  assign w_last      = (k_q == c_last_k) && (state_q == DRAIN);
  assign k_d         = k_q + 1'b1;
  assign load_ack    = (state_q == IDLE) | (w_last & drain_ready);
  assign w_load      = load_req & load_ack;
  assign drain_valid = (state_q == DRAIN);
  assign drain_last  = w_last;
  assign busy        = (state_q != IDLE);
  assign drain_col   = dir_q ? (c_last_k - k_q) : k_q;

  // A load covers both the idle start and the back-to-back reload on the
  // final handshake, so the snapshot can never change mid-drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      snap_q   <= '{default: '0};
      row_en_q <= '0;
      dir_q    <= 1'b0;
      shift_q  <= '0;
    end else if (w_load) begin
      state_q  <= DRAIN;
      k_q      <= '0;
      row_en_q <= row_en;
      dir_q    <= drain_dir;
      shift_q  <= out_shift;
      for (int r = 0; r < NB_PE_ROW; r++) begin
        for (int c = 0; c < NB_PE_COL; c++) begin
          snap_q[r][c] <= pe_out_all[(r*NB_PE_COL + c)*OUTPUT_WIDTH +: OUTPUT_WIDTH];
        end
      end
    end else if ((state_q == DRAIN) && drain_ready) begin
      if (w_last) begin
        state_q <= IDLE;
        k_q     <= '0;
      end else begin
        k_q     <= k_d;
      end
    end
  end

  for (genvar r = 0; r < NB_PE_ROW; r++) begin : g_lane
    pe_drain_lane #(
      .OUTPUT_WIDTH (OUTPUT_WIDTH),
      .OBF_WIDTH    (OBF_WIDTH)
    ) u_lane (
      .pe_val_i (snap_q[r][drain_col]),
      .shift_i  (shift_q),
      .en_i     (row_en_q[r]),
      .lane_o   (drain_data[r*OBF_WIDTH +: OBF_WIDTH])
    );
  end

endmodule
`default_nettype wire

// File: doc/pe_array_drain.md
Name: pe_array_drain

Overview:
- Output collector that sits between the PE array and the output buffer (OBF).
- On a load handshake it snapshots the outputs of every PE, all rows and all columns, in a single cycle.
- It then drains the snapshot one column per beat to the OBF over a valid/ready interface, and rescales each lane to the OBF word width.
- Supersedes the fixed last-column-only tap: any column order, row masking and backpressure are supported.

Parameters:
- nb_pe_row, 8, PE rows (lanes per beat)
- nb_pe_col, 32, PE columns (beats per drain)
- output_width, 24, signed PE output width
- obf_width, 16, signed OBF lane width (must be <= output_width)
- col_idx_width, $clog2(nb_pe_col), beat index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pe_out_all  in  nb_pe_row*nb_pe_col*output_width  all PE outputs; row r, col c at slice index (r*nb_pe_col+c)
- load_req  in  1  request to snapshot pe_out_all
- load_ack  out  1  snapshot taken this cycle when load_req&&load_ack
- row_en  in  nb_pe_row  lane mask, sampled at load
- drain_dir  in  1  sampled at load; 0 = col 0 first, 1 = col nb_pe_col-1 first
- out_shift  in  5  arithmetic right shift per lane, sampled at load, legal 0..output_width-1
- drain_valid  out  1  beat valid
- drain_ready  in  1  OBF accepts beat
- drain_data  out  nb_pe_row*obf_width  lane r at [(r+1)*obf_width-1 -: obf_width]
- drain_col  out  col_idx_width  column index of current beat
- drain_last  out  1  current beat is final column
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state IDLE; snapshot regs 0; beat counter 0; drain_valid 0; drain_last 0; drain_col 0; busy 0; drain_data 0; load_ack 1.
- FSM states:
  - IDLE: load_ack=1; on load_req go to DRAIN.
  - DRAIN: drain_valid=1.
    - Each handshake (drain_valid&&drain_ready) advances the counter.
    - On the last handshake, go to IDLE, unless load_req is also high: then a back-to-back reload occurs and the state stays DRAIN.
- load_ack = (state==IDLE) | (state==DRAIN && drain_last && drain_ready). It is combinational.
- Load edge:
  - Captures pe_out_all, row_en, drain_dir and out_shift.
  - Clears the counter.
  - The first beat is valid the next cycle (1-cycle latency).
- Beat mapping:
  - Counter k counts 0..nb_pe_col-1.
  - drain_col = k if drain_dir=0, else nb_pe_col-1-k.
  - drain_last = (k==nb_pe_col-1) && state==DRAIN.
- Lane arithmetic:
  - v = snapshot[r][drain_col] >>> out_shift (sign-preserving).
  - Narrow v to obf_width as set by the macro under Optional Feature.
  - Lanes with row_en[r]=0 output 0.
- Outputs are combinational from registered state only, with no input-to-output path except load_ack←drain_ready.
- drain_data, drain_col and drain_last stay stable while drain_valid&&!drain_ready.
- Backpressure: drain_ready low holds the beat indefinitely, with no counter advance.
- load_req in DRAIN other than on the last handshake is ignored (load_ack=0). The snapshot is never overwritten mid-drain.
- rst mid-drain: next cycle IDLE, drain_valid=0, the in-flight beat is dropped and the snapshot is zeroed.
- nb_pe_col=1: every beat is last; back-to-back loads give one beat per cycle.

Optional Feature:
- Macro PEARRAY_DRAIN_SAT_EN.
- Defined: saturate v to the signed obf_width range [-2^(obf_width-1), 2^(obf_width-1)-1].
  - Example: v=40000 with obf_width=16 gives 32767.
- Undefined: truncate to v[obf_width-1:0] (wraps).
  - Example: v=40000 gives -25536 (0x9C40).

Decomposition:
- Shared package pe_array_pkg:
  - state enum {IDLE, DRAIN}
  - default widths (output_width, obf_width)
  - function sat_or_trunc
- One sub-module, pe_drain_lane: per-lane shift, narrow and mask logic, instantiated nb_pe_row times via generate.
- FSM, counter and snapshot registers stay in the top module.

Test Plan:
- Load pattern value=(r<<8)|c, drain_dir=0, out_shift=0, row_en=all 1, ready=1:
  - 32 consecutive beats, drain_col 0..31.
  - Lane r of beat c = (r<<8)|c.
  - drain_last on beat 31; busy drops on the following cycle.
- Same load with drain_dir=1 and drain_ready toggling 1,0,0,1 periodically:
  - Columns emitted 31..0.
  - Data held stable during stalls; no beats lost or duplicated; beat count = 32.
- load_req held high through a drain:
  - load_ack=1 only in IDLE and on the beat-31 handshake.
  - Second snapshot's beat 0 valid in the cycle right after beat 31, with no idle bubble.
- PE value 40000 (0x009C40), out_shift=0, obf_width=16:
  - With PEARRAY_DRAIN_SAT_EN: 32767.
  - Without: 0x9C40.
  - Value -512 with out_shift=4 gives -32 in both builds.
- row_en=8'b1010_0101: lanes 1, 3, 4 and 6 output 0 on every beat; the other lanes carry correct data.
- Assert rst on beat 10 of a drain:
  - Next cycle drain_valid=0, busy=0, load_ack=1, drain_data=0.
  - A new load then drains from drain_col 0.
